fetch_pc_gen: RTL
=================

FETCH_PC_GEN -- requirements
Module: fetch_pc_gen

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32: width of PC, target and address fields.
REQ-002 SHALL have parameter BTB_ENTRIES, default 16: number of BTB entries, a power of two, at least 2; IDX_W = log2(BTB_ENTRIES).
REQ-003 SHALL have parameter RESET_PC, default 0: PC value loaded on reset.
REQ-004 SHALL use one clock and a synchronous, active-high reset.
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all state updates on posedge.
REQ-006 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-007 SHALL have port pc_write, input, 1 bit: 0 holds the PC (stall); paired with the IF/ID write enable.
REQ-008 SHALL have port redirect, input, 1 bit: EX-stage misprediction or jump; forces the next PC to redirect_PC.
REQ-009 SHALL have port redirect_PC, input, DATA_WIDTH bits: the correct next PC.
REQ-010 SHALL have port update_en, input, 1 bit: a resolved branch in EX updates the BTB.
REQ-011 SHALL have ports update_PC and update_target, inputs, DATA_WIDTH bits each: the resolved branch's PC and its taken target.
REQ-012 SHALL have port update_taken, input, 1 bit: the resolved branch direction.
REQ-013 SHALL have ports if_PC and if_pc_plus_4, outputs, DATA_WIDTH bits each: the current fetch PC (also the imem address) and that PC + 4.
REQ-014 SHALL have ports if_pred and if_hit, outputs, 1 bit each: the predicted-taken flag and the BTB tag-hit flag, both for if_PC.
REQ-015 SHALL have port if_pred_PC_target, output, DATA_WIDTH bits: the BTB target for if_PC, and 0 when if_hit = 0.

Function
REQ-016 SHALL split if_PC into index = PC[IDX_W+1:2] and tag = PC[DATA_WIDTH-1:IDX_W+2]; PC[1:0] SHALL be ignored.
REQ-017 SHALL keep, per BTB entry, a valid bit, a tag, a DATA_WIDTH target and a 2-bit saturating counter.
REQ-018 SHALL perform the lookup combinationally from the registered if_PC: if_hit = valid && tag match; if_pred = if_hit && counter[1].
REQ-019 SHALL load the PC each cycle by this priority: reset -> RESET_PC; redirect -> redirect_PC (redirect overrides pc_write = 0); pc_write = 0 -> hold; if_pred -> if_pred_PC_target; otherwise -> if_pc_plus_4.
REQ-020 SHALL compute if_pc_plus_4 as a DATA_WIDTH-bit sum that wraps modulo 2^DATA_WIDTH.
REQ-021 SHALL perform BTB updates when update_en = 1, independent of pc_write and redirect, and they SHALL become visible one cycle later.
REQ-022 SHALL apply a same-cycle lookup of an entry being written to the old contents.
REQ-023 SHALL handle an update that hits (valid, index and tag match) as follows: update_taken = 1 increments the counter, saturating at 3, and writes the target; update_taken = 0 decrements the counter, saturating at 0, and leaves the target unchanged.
REQ-024 SHALL handle an update that misses as follows: update_taken = 1 allocates the entry (overwriting any occupant) with valid = 1, tag, target and counter = 2; update_taken = 0 leaves the BTB unchanged.
REQ-025 SHALL NOT update the BTB when update_en = 0, for any value of the other update_* inputs.

Reset
REQ-026 SHALL, on reset, set the PC to RESET_PC, so that if_pc_plus_4 = RESET_PC + 4.
REQ-027 SHALL, on reset, set every valid bit to 0 and every counter to 1; targets and tags need not be reset.
REQ-028 SHALL hold if_hit = 0, if_pred = 0 and if_pred_PC_target = 0 in the first cycle after reset.
REQ-029 SHALL let reset take priority over redirect, pc_write and update_en, and SHALL discard an update arriving in the reset cycle.

Configuration
REQ-030 SHALL implement 2-bit counters as described above when macro BTB_2BIT_COUNTER_EN is defined.
REQ-031 SHALL, without BTB_2BIT_COUNTER_EN, store no counter: if_pred = if_hit; a taken update writes the entry; a not-taken update that hits clears the valid bit.

Verification
REQ-032 SHALL verify reset then free-run: reset for 2 cycles, then pc_write = 1 -> if_PC = 0, 4, 8, 12 and if_hit = 0 throughout.
REQ-033 SHALL verify allocate and predict: update PC = 0x10, taken, target 0x80 -> the next visit to 0x10 gives if_hit = 1, if_pred = 1 and target 0x80, and the following if_PC = 0x80.
REQ-034 SHALL verify counter saturation: 3 taken then 2 not-taken updates at 0x10 -> counter 3 -> 1, then if_hit = 1 and if_pred = 0 at 0x10, with next PC 0x14.
REQ-035 SHALL verify redirect over stall: pc_write = 0 and redirect = 1 with redirect_PC = 0x200 -> next if_PC = 0x200; pc_write = 0 alone -> if_PC held for 3 cycles.
REQ-036 SHALL verify an alias conflict with BTB_ENTRIES = 16: taken updates at 0x10 then 0x50 (same index) -> 0x10 misses and 0x50 hits.
REQ-037 SHALL verify wrap and reset mid-run: if_PC = 0xFFFFFFFC -> if_pc_plus_4 = 0 and next PC 0; reset asserted with a pending update -> all entries invalid afterwards.

Source files
------------

// File: rtl/fetch_pc_gen.sv
// Fetch PC generator with a direct-mapped branch target buffer (BTB).
// Latency: PC registered; BTB lookup is combinational from if_PC; BTB writes are visible next cycle.
// Backpressure: pc_write=0 holds the PC, and redirect overrides the hold; BTB updates ignore both.
// Optional feature macro: BTB_2BIT_COUNTER_EN adds 2-bit saturating direction counters.
// Without it, a hit predicts taken and a not-taken update that hits invalidates the entry.

module fetch_pc_gen #(
  parameter int                    DATA_WIDTH  = 32,
  parameter int                    BTB_ENTRIES = 16,
  parameter logic [DATA_WIDTH-1:0] RESET_PC    = '0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  pc_write,
  input  logic                  redirect,
  input  logic [DATA_WIDTH-1:0] redirect_PC,
  input  logic                  update_en,
  input  logic [DATA_WIDTH-1:0] update_PC,
  input  logic [DATA_WIDTH-1:0] update_target,
  input  logic                  update_taken,
  output logic [DATA_WIDTH-1:0] if_PC,
  output logic [DATA_WIDTH-1:0] if_pc_plus_4,
  output logic                  if_pred,
  output logic                  if_hit,
  output logic [DATA_WIDTH-1:0] if_pred_PC_target
);

  localparam int IDX_W = $clog2(BTB_ENTRIES);
  localparam int TAG_W = DATA_WIDTH - IDX_W - 2;

  // Fetch PC
  logic [DATA_WIDTH-1:0] r_pc;
  logic [DATA_WIDTH-1:0] w_pc_nxt;
  logic [DATA_WIDTH-1:0] w_pc_plus_4;

  // BTB storage
  logic [BTB_ENTRIES-1:0] r_valid;
  logic [TAG_W-1:0]       r_tag    [BTB_ENTRIES];
  logic [DATA_WIDTH-1:0]  r_target [BTB_ENTRIES];
`ifdef BTB_2BIT_COUNTER_EN
  logic [1:0]             r_ctr    [BTB_ENTRIES];
  logic [1:0]             w_upd_ctr;
  logic [1:0]             w_ctr_nxt;
  logic                   w_ctr_we;
`endif

  // Lookup side
  logic [IDX_W-1:0] w_if_idx;
  logic [TAG_W-1:0] w_if_tag;
  logic             w_if_hit;
  logic             w_if_pred;

  // Update side
  logic [IDX_W-1:0] w_upd_idx;
  logic [TAG_W-1:0] w_upd_tag;
  logic             w_upd_hit;
  logic             w_upd_go;
  logic             w_wr_entry;
  logic             w_clr_valid;

  // The low two address bits never take part in indexing or tagging.
  logic w_unused;
  assign w_unused = &{1'b0, update_PC[1:0]};

  // Split the fetch PC into index and tag and probe the BTB.
  always_comb begin
    w_if_idx = r_pc[IDX_W+1:2];
    w_if_tag = r_pc[DATA_WIDTH-1:IDX_W+2];
    w_if_hit = r_valid[w_if_idx] && (r_tag[w_if_idx] == w_if_tag);
`ifdef BTB_2BIT_COUNTER_EN
    w_if_pred = w_if_hit && r_ctr[w_if_idx][1];
`else
    w_if_pred = w_if_hit;
`endif
  end

  // Drive the fetch-side outputs; target reads as zero on a miss.
  always_comb begin
    w_pc_plus_4       = r_pc + DATA_WIDTH'(4);
    if_PC             = r_pc;
    if_pc_plus_4      = w_pc_plus_4;
    if_hit            = w_if_hit;
    if_pred           = w_if_pred;
    if_pred_PC_target = w_if_hit ? r_target[w_if_idx] : '0;
  end

  // Next-PC selection: redirect beats stall, stall beats prediction.
  always_comb begin
    if (redirect) begin
      w_pc_nxt = redirect_PC;
    end else if (!pc_write) begin
      w_pc_nxt = r_pc;
    end else if (w_if_pred) begin
      w_pc_nxt = if_pred_PC_target;
    end else begin
      w_pc_nxt = w_pc_plus_4;
    end
  end

  // PC register; reset has the highest priority.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc <= RESET_PC;
    end else begin
      r_pc <= w_pc_nxt;
    end
  end

  // Decode a resolved branch into BTB write actions; nothing happens during reset.
  always_comb begin
    w_upd_idx   = update_PC[IDX_W+1:2];
    w_upd_tag   = update_PC[DATA_WIDTH-1:IDX_W+2];
    w_upd_hit   = r_valid[w_upd_idx] && (r_tag[w_upd_idx] == w_upd_tag);
    w_upd_go    = update_en && !reset;
    // Taken branches always (re)write tag and target: refresh on hit, allocate on miss.
    w_wr_entry  = w_upd_go && update_taken;
`ifdef BTB_2BIT_COUNTER_EN
    w_clr_valid = 1'b0;
`else
    w_clr_valid = w_upd_go && !update_taken && w_upd_hit;
`endif
  end

`ifdef BTB_2BIT_COUNTER_EN
  // Counter next value: saturating step on a hit, weakly-taken on a fresh allocation.
  always_comb begin
    w_upd_ctr = r_ctr[w_upd_idx];
    w_ctr_nxt = w_upd_ctr;
    w_ctr_we  = 1'b0;
    if (w_upd_go) begin
      if (w_upd_hit) begin
        w_ctr_we = 1'b1;
        if (update_taken) begin
          w_ctr_nxt = (w_upd_ctr == 2'b11) ? 2'b11 : w_upd_ctr + 2'b01;
        end else begin
          w_ctr_nxt = (w_upd_ctr == 2'b00) ? 2'b00 : w_upd_ctr - 2'b01;
        end
      end else if (update_taken) begin
        w_ctr_we  = 1'b1;
        w_ctr_nxt = 2'b10;
      end
    end
  end

  // Counter array; reset leaves every entry weakly not-taken.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < BTB_ENTRIES; i++) begin
        r_ctr[i] <= 2'b01;
      end
    end else if (w_ctr_we) begin
      r_ctr[w_upd_idx] <= w_ctr_nxt;
    end
  end
`endif

  // Valid bits: cleared on reset, set on allocate, cleared by a not-taken hit when counters are absent.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid <= '0;
    end else if (w_wr_entry) begin
      r_valid[w_upd_idx] <= 1'b1;
    end else if (w_clr_valid) begin
      r_valid[w_upd_idx] <= 1'b0;
    end
  end

  // Tag and target payload; no reset needed because valid gates every use.
  always_ff @(posedge clk) begin
    if (w_wr_entry) begin
      r_tag[w_upd_idx]    <= w_upd_tag;
      r_target[w_upd_idx] <= update_target;
    end
  end

endmodule
